// File: rtl/axis_delay_pipe.sv
// AXI4-Stream delay line of DEPTH bubble-collapsing register stages.
// Define AXIS_DELAY_PIPE_OCC_EN to add the registered occupancy_o count.
module axis_delay_pipe #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int DEPTH           = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         s_axis_tvalid,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic                         m_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready
`ifdef AXIS_DELAY_PIPE_OCC_EN
    ,
    output logic [5:0]                   occupancy_o
`endif
);

    localparam int SW = AXIS_DATA_WIDTH / 8;

    generate
        if (DEPTH == 0) begin : g_pass
            assign m_axis_tvalid = s_axis_tvalid;
            assign m_axis_tdata  = s_axis_tdata;
            assign m_axis_tstrb  = s_axis_tstrb;
            assign m_axis_tlast  = s_axis_tlast;
            assign s_axis_tready = m_axis_tready;
`ifdef AXIS_DELAY_PIPE_OCC_EN
            assign occupancy_o   = 6'd0;
`endif
        end else begin : g_pipe
            logic [DEPTH-1:0]                      valid_q, valid_d;
            logic [DEPTH-1:0][AXIS_DATA_WIDTH-1:0] data_q, data_d;
            logic [DEPTH-1:0][SW-1:0]              strb_q, strb_d;
            logic [DEPTH-1:0]                      last_q, last_d;
            logic [DEPTH-1:0]                      adv;
            logic                                  s_ready;
            logic                                  load;

            // Walk from the output side: a stage can take a beat when it is
            // empty or everything downstream of it is moving.
            always_comb begin : p_ready
                logic go;
                go = m_axis_tready;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    adv[i] = valid_q[i] & go;
                    go     = ~valid_q[i] | go;
                end
                s_ready = go;
            end

            assign load = s_axis_tvalid & s_ready;

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                strb_d  = strb_q;
                last_d  = last_q;
                if (load) begin
                    valid_d[0] = 1'b1;
                    data_d[0]  = s_axis_tdata;
                    strb_d[0]  = s_axis_tstrb;
                    last_d[0]  = s_axis_tlast;
                end else if (adv[0]) begin
                    valid_d[0] = 1'b0;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    if (adv[i-1]) begin
                        valid_d[i] = 1'b1;
                        data_d[i]  = data_q[i-1];
                        strb_d[i]  = strb_q[i-1];
                        last_d[i]  = last_q[i-1];
                    end else if (adv[i]) begin
                        valid_d[i] = 1'b0;
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_q <= '0;
                    data_q  <= '0;
                    strb_q  <= '0;
                    last_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                    strb_q  <= strb_d;
                    last_q  <= last_d;
                end
            end

            assign s_axis_tready = s_ready;
            assign m_axis_tvalid = valid_q[DEPTH-1];
            assign m_axis_tdata  = data_q[DEPTH-1];
            assign m_axis_tstrb  = strb_q[DEPTH-1];
            assign m_axis_tlast  = last_q[DEPTH-1];

`ifdef AXIS_DELAY_PIPE_OCC_EN
            logic [5:0] occ_q, occ_d;
            logic       emit;

            assign emit = adv[DEPTH-1];

            always_comb begin
                occ_d = occ_q;
                if (load && !emit) begin
                    occ_d = occ_q + 6'd1;
                end else if (emit && !load) begin
                    occ_d = occ_q - 6'd1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    occ_q <= 6'd0;
                end else begin
                    occ_q <= occ_d;
                end
            end

            assign occupancy_o = occ_q;
`endif
        end
    endgenerate

endmodule
